// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and constants for the handshaked register file
// Purpose: handshake state encoding, default geometry, PC index helper.
// Ports: none (package).
package reg_file_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } hs_state_e;

    localparam int DEF_DW     = 32;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_NUM_RD = 3;
    localparam int DEF_NUM_WR = 4;

    // The top register of the array doubles as the program counter.
    function automatic int pc_index(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/reg_file_hs_ctrl.sv
// rtl/reg_file_hs_ctrl.sv - 4-phase req/ack handshake sequencer for the register file
// Purpose: IDLE -> EXEC (one cycle) -> DONE; emits a one-cycle commit strobe in EXEC
//          and a registered acknowledge.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_i        level request from the requester
//   ack_o        acknowledge, high while the transaction is complete and req still held
//   commit_o     high for the single EXEC cycle; the array updates on the edge ending it
module reg_file_hs_ctrl
    import reg_file_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    output logic ack_o,
    output logic commit_o
);

    hs_state_e state_q, state_d;
    logic      ack_q, ack_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_i)  state_d = ST_EXEC;
            ST_EXEC:             state_d = ST_DONE;
            ST_DONE: if (!req_i) state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    // ack is registered: it rises on the edge after the commit edge and falls on
    // the same edge that returns the FSM to IDLE, so it never glitches.
    always_comb begin
        commit_o = (state_q == ST_EXEC);
        ack_d    = (state_q == ST_DONE) && (state_d == ST_DONE);
    end

    assign ack_o = ack_q;

endmodule

// File: rtl/reg_file_hs.sv
// rtl/reg_file_hs.sv - parametrised multi-port register file behind a 4-phase handshake
// Purpose: NUM_WR write ports with highest-index-wins priority, NUM_RD registered read
//          ports, register DEPTH-1 aliased as PC (pc_write overrides port writes there),
//          separate CPSR. All state changes happen only on the EXEC commit edge.
// Optional: define REG_FILE_BYPASS_EN to make same-transaction reads return the winning
//           write value instead of the pre-transaction value.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req / ack                4-phase handshake
//   rd_en/rd_addr/rd_data    packed read ports, port i at [i*AW +: AW] / [i*DW +: DW]
//   wr_en/wr_addr/wr_data    packed write ports
//   pc_write/pc_update       PC load
//   cpsr_write/cpsr_update   CPSR load
//   pc, cpsr                 current PC (register DEPTH-1) and CPSR
module reg_file_hs
    import reg_file_pkg::*;
#(
    parameter int             DW       = DEF_DW,
    parameter int             DEPTH    = DEF_DEPTH,
    parameter int             NUM_RD   = DEF_NUM_RD,
    parameter int             NUM_WR   = DEF_NUM_WR,
    parameter logic [DW-1:0]  PC_RESET = '0,
    localparam int            AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    output logic                 ack,
    input  logic [NUM_RD-1:0]    rd_en,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR*DW-1:0] wr_data,
    input  logic                 pc_write,
    input  logic [DW-1:0]        pc_update,
    input  logic                 cpsr_write,
    input  logic [DW-1:0]        cpsr_update,
    output logic [DW-1:0]        pc,
    output logic [DW-1:0]        cpsr
);

    localparam logic [AW-1:0] PC_ADDR = AW'(pc_index(DEPTH));

    logic [DW-1:0] regs_q [DEPTH];
    logic [DW-1:0] regs_d [DEPTH];
    logic [DW-1:0] rd_q   [NUM_RD];
    logic [DW-1:0] rd_d   [NUM_RD];
    logic [DW-1:0] cpsr_q, cpsr_d;
    logic          commit;

    reg_file_hs_ctrl u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .ack_o    (ack),
        .commit_o (commit)
    );

    // Ports are applied in ascending order so the highest-index port lands last,
    // then the PC load overrides whatever a port put at the PC address.
    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w]) regs_d[wr_addr[w*AW +: AW]] = wr_data[w*DW +: DW];
            end
            if (pc_write) regs_d[PC_ADDR] = pc_update;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_d[i] = rd_q[i];
            if (commit && rd_en[i]) begin
`ifdef REG_FILE_BYPASS_EN
                rd_d[i] = regs_d[rd_addr[i*AW +: AW]];
`else
                rd_d[i] = regs_q[rd_addr[i*AW +: AW]];
`endif
            end
        end
        cpsr_d = (commit && cpsr_write) ? cpsr_update : cpsr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
            regs_q[PC_ADDR] <= PC_RESET;
            for (int i = 0; i < NUM_RD; i++) rd_q[i] <= '0;
            cpsr_q <= '0;
        end else begin
            regs_q <= regs_d;
            rd_q   <= rd_d;
            cpsr_q <= cpsr_d;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_out
        assign rd_data[g*DW +: DW] = rd_q[g];
    end

    assign pc   = regs_q[PC_ADDR];
    assign cpsr = cpsr_q;

endmodule

// File: doc/reg_file_hs.md
Name: reg_file_hs

Overview:
- Parametrised multi-port register file with a 4-phase req/ack handshake.
- Successor to the fixed 4-write/3-read async register file.
- Generalised in data width, depth, and read/write port count.
- Adds deterministic write-conflict priority, R15/PC aliasing, CPSR register and asynchronous active-low reset.
- Sits between the async_clk handshake source and the datapath (multiplier, ALU operand fetch/writeback).

Parameters:
- DW, 32, data width in bits.
- DEPTH, 16, number of registers; power of 2, at least 4. Top index DEPTH-1 aliases PC.
- NUM_RD, 3, number of read ports.
- NUM_WR, 4, number of write ports.
- PC_RESET, 0, PC value after reset.
- AW (localparam), $clog2(DEPTH), address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  transaction request, level, 4-phase.
- ack  out  1  transaction acknowledge.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i at [i*AW +: AW].
- rd_data  out  NUM_RD*DW  packed registered read data.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AW  packed write addresses.
- wr_data  in  NUM_WR*DW  packed write data.
- pc_write  in  1  PC update strobe.
- pc_update  in  DW  new PC value.
- cpsr_write  in  1  CPSR update strobe.
- cpsr_update  in  DW  new CPSR value.
- pc  out  DW  current PC (register DEPTH-1).
- cpsr  out  DW  current CPSR.

Behaviour:
- Reset (rst_n=0, async):
  - all registers 0; pc=PC_RESET; cpsr=0; rd_data=0; ack=0; FSM=IDLE.
  - Reset mid-transaction aborts it. Writes not yet committed at an EXEC edge are lost.
- FSM states IDLE, EXEC, DONE:
  - IDLE: ack=0. req=1 sampled at an edge -> EXEC.
  - EXEC (exactly 1 cycle): commit all enabled writes, capture all enabled reads -> DONE.
  - DONE: ack=1, held. req=0 sampled -> IDLE; ack falls at that edge.
- Latency: req sampled high at edge N -> writes commit at edge N+1 -> ack high after edge N+2.
- A new transaction is accepted only after ack has dropped. req held high while IDLE (after a return to IDLE) starts a new transaction.
- Requester holds all inputs stable from req rise until ack rise. Input changes in DONE are ignored.
- Reads:
  - Read-before-write: rd_data[i] gets the pre-transaction value of rd_addr[i].
  - rd_en[i]=0 holds the previous rd_data[i].
  - Address DEPTH-1 returns pc.
- Write conflicts:
  - Multiple ports to the same address: highest-index port wins.
  - pc_write=1 overrides any port write to DEPTH-1.
  - A port write to DEPTH-1 without pc_write updates pc.
- cpsr_write loads cpsr_update in EXEC. It is independent of the register array.
- All state changes occur only in the EXEC cycle. pc and cpsr are stable otherwise.
- No arithmetic. Widths are exact; no truncation or extension.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: a read whose address matches an enabled write in the same transaction returns the winning write value, including the pc_write override at DEPTH-1.
- Undefined: read-before-write as above.
- Handshake timing is identical either way.

Decomposition:
- Shared package reg_file_pkg holds:
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, DONE=2'd2);
  - default width/depth constants;
  - a PC_INDEX function (DEPTH-1).
- One sub-module, reg_file_hs_ctrl, is natural: the handshake FSM, producing ack and a one-cycle commit strobe.
- Array, priority resolution and read muxing stay in the top module.

Test Plan:
- Reset then single write: wr_en[0]=1, addr 0, data 0x2, req pulse -> ack high 2 cycles after req sampled; next read of addr 0 on port 0 gives rd_data[0]=0x2.
- Multiplier loop: write R0=2, R1=2; read both; repeatedly write R2=result and read R2 back for 29 transactions -> each readback equals the prior written value; ack toggles once per transaction.
- Write conflict: ports 0..3 all write addr 5 with 0x10,0x20,0x30,0x40 -> R5=0x40.
- PC alias: port 1 writes addr 15 with 0x100 and pc_write=1, pc_update=0x200 -> pc=0x200, and reading addr 15 gives 0x200. Repeat with pc_write=0 -> pc=0x100.
- Same-transaction read/write of addr 3 (old 0x7, new 0x9) -> rd_data=0x7 without REG_FILE_BYPASS_EN, 0x9 with it.
- rst_n low during EXEC of a write 0xDEAD to addr 4 -> R4=0, ack=0, pc=PC_RESET; after release, the next req completes normally.
